// File: rtl/fp_pkg.sv
// fp_pkg: definitions shared by the binary32 post-normalisation stage.
//   - field widths and the saturated exponent value
//   - width of the internal mantissa (carry + hidden + fraction) and
//     of the internal signed exponent
//   - FSM state type and the packed-result struct
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // carry bit + hidden bit + fraction
  localparam int MANT_W = FRAC_W + 2;
  // Two extra bits so exp+1 from 0xFF and exp-1 from 0x01 cannot wrap.
  localparam int XEXP_W = EXP_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } fp_norm_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // Widen an 8-bit biased exponent into the internal signed form.
  function automatic logic signed [XEXP_W-1:0] fp_widen_exp(input logic [EXP_W-1:0] e);
    return $signed({2'b00, e});
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational 24-bit leading-zero counter.
//   in_i  [23:0]  value to scan (bit 23 is the most significant)
//   cnt_o [4:0]   number of leading zeros; 24 when in_i is all zero
module fp_lzc (
  input  logic [23:0] in_i,
  output logic [4:0]  cnt_o
);

  // Ascending scan: the highest set bit is the last one to write cnt_o.
  always_comb begin
    cnt_o = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (in_i[i]) cnt_o = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp_normalize.sv
// fp_normalize: post-normalisation and rounding for the binary32 adder.
// Takes the adder's raw sign/exponent/25-bit mantissa/round hint, brings
// the leading one to bit 23, applies the round increment and packs an
// IEEE-754 single with zero/negative/carry/overflow flags.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    input handshake (accepted only in IDLE)
//   in_sign, in_exp      sign and biased exponent of the raw result
//   in_mant[24:0]        [24] carry, [23] hidden bit, [22:0] fraction
//   in_round             round-up hint from the adder
//   out_valid/out_ready  output handshake; y and flags hold in DONE
//   y[31:0]              packed result {sign, exp, frac}
//   z, n, c, o           zero, negative, mantissa-carry, exponent overflow
//
// Build option
//   FP_NORM_FAST_EN  when defined, NORM uses fp_lzc and does the whole left
//                    shift in one cycle (fixed latency). Otherwise it shifts
//                    one bit per cycle. Results are identical either way.
module fp_normalize
  import fp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXP_W-1:0]      in_exp,
  input  logic [MANT_W-1:0]     in_mant,
  input  logic                  in_round,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           y,
  output logic                  z,
  output logic                  n,
  output logic                  c,
  output logic                  o
);

  fp_norm_state_t state_q, state_d;

  logic                     sign_q, sign_d;
  logic signed [XEXP_W-1:0] exp_q, exp_d;
  logic [MANT_W-1:0]        mant_q, mant_d;
  logic                     rnd_q, rnd_d;
  logic                     cr_q, cr_d;

  fp32_t                    res_q, res_d;
  logic                     z_q, z_d;
  logic                     n_q, n_d;
  logic                     c_q, c_d;
  logic                     o_q, o_d;
  logic                     ov_q, ov_d;

  // ---------------------------------------------------------------------
  // Rounding datapath (used in ROUND)
  // ---------------------------------------------------------------------
  logic [FRAC_W+1:0]        frac_sum;  // 25 bits: carry out of frac24
  logic [FRAC_W:0]          mant_rnd;  // 24 bits: hidden + fraction
  logic signed [XEXP_W-1:0] exp_rnd;

  assign frac_sum = {1'b0, mant_q[FRAC_W:0]} + {{(FRAC_W+1){1'b0}}, rnd_q};

  always_comb begin
    mant_rnd = frac_sum[FRAC_W:0];
    exp_rnd  = exp_q;
    // 0xFFFFFF + 1: mantissa becomes 1.0 and the exponent moves up.
    if (frac_sum[FRAC_W+1]) begin
      mant_rnd = 24'h800000;
      exp_rnd  = exp_q + 10'sd1;
    end
  end

`ifdef FP_NORM_FAST_EN
  // ---------------------------------------------------------------------
  // Single-cycle left shift: min(lzc, exp-1)
  // ---------------------------------------------------------------------
  logic [4:0]               lzc;
  logic signed [XEXP_W-1:0] exp_m1;
  logic [4:0]               shamt;

  fp_lzc u_lzc (
    .in_i  (mant_q[FRAC_W:0]),
    .cnt_o (lzc)
  );

  assign exp_m1 = exp_q - 10'sd1;

  // Only consulted when mant[24]=0, mant[23]=0, mant!=0 and exp>1, so
  // lzc is in 1..23 and exp_m1 >= 1; the clamp keeps exp from going below 1.
  always_comb begin
    if (exp_m1 < $signed({5'b0, lzc})) shamt = exp_m1[4:0];
    else                               shamt = lzc;
  end
`endif

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    rnd_d   = rnd_q;
    cr_d    = cr_q;
    res_d   = res_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    o_d     = o_q;
    ov_d    = ov_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = fp_widen_exp(in_exp);
          mant_d  = in_mant;
          rnd_d   = in_round;
          cr_d    = in_mant[MANT_W-1];
          state_d = NORM;
        end
      end

      NORM: begin
        if (mant_q == '0) begin
          state_d = ROUND;
        end else if (mant_q[MANT_W-1]) begin
          // Carry: one right shift, sticky the dropped bit into the hint.
          mant_d  = mant_q >> 1;
          exp_d   = exp_q + 10'sd1;
          rnd_d   = rnd_q | mant_q[0];
          state_d = ROUND;
        end else if (mant_q[FRAC_W] || (exp_q <= 10'sd1)) begin
          state_d = ROUND;
        end else begin
`ifdef FP_NORM_FAST_EN
          mant_d  = mant_q << shamt;
          exp_d   = exp_q - $signed({5'b0, shamt});
          state_d = ROUND;
`else
          mant_d  = mant_q << 1;
          exp_d   = exp_q - 10'sd1;
`endif
        end
      end

      ROUND: begin
        z_d = 1'b0;
        o_d = 1'b0;
        if (exp_rnd >= $signed({2'b00, EXP_MAX})) begin
          res_d = '{sign: sign_q, exp: EXP_MAX, frac: '0};
          o_d   = 1'b1;
        end else if (!mant_rnd[FRAC_W]) begin
          // Zero or denormal: flushed to +0.
          res_d = '0;
          z_d   = 1'b1;
        end else begin
          res_d = '{sign: sign_q, exp: exp_rnd[EXP_W-1:0], frac: mant_rnd[FRAC_W-1:0]};
        end
        n_d     = sign_q & ~z_d;
        c_d     = cr_q;
        ov_d    = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      rnd_q   <= 1'b0;
      cr_q    <= 1'b0;
      res_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      o_q     <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      rnd_q   <= rnd_d;
      cr_q    <= cr_d;
      res_q   <= res_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      o_q     <= o_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = ov_q;
  assign y         = res_q;
  assign z         = z_q;
  assign n         = n_q;
  assign c         = c_q;
  assign o         = o_q;

endmodule

// File: tb/tb_fp_normalize.sv
module tb_fp_normalize;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        in_round;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        z, n, c, o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_normalize dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_round  (in_round),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .z         (z),
    .n         (n),
    .c         (c),
    .o         (o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: works on plain integers. Finds the leading one, shifts it
  // to bit 23 bounded by the exponent floor of 1, rounds, then packs.
  // flags = {z,n,c,o}; lat = edges from the accept edge (inclusive) to the
  // edge after which out_valid is seen high.
  function automatic void model(input logic s, input logic [7:0] e,
                                input logic [24:0] m, input logic r,
                                output logic [31:0] ey, output logic [3:0] ef,
                                output int lat);
    int ex, mm, rr, k, msb, frac;
    logic ez, eo;
    ex = e; mm = m; rr = r; k = 0;
    if (mm >= (1 << 24)) begin
      rr = rr | (mm & 1);
      mm = mm / 2;
      ex = ex + 1;
    end else if (mm != 0) begin
      msb = 0;
      for (int i = 0; i < 24; i++) if (mm >= (1 << i)) msb = i;
      k = 23 - msb;
      if (ex <= 1) k = 0;
      else if (k > ex - 1) k = ex - 1;
      mm = mm * (1 << k);
      ex = ex - k;
    end
    frac = mm + rr;
    if (frac >= (1 << 24)) begin
      frac = 1 << 23;
      ex = ex + 1;
    end
    ez = 1'b0; eo = 1'b0;
    if (ex >= 255) begin
      ey = {s, 8'hFF, 23'h0};
      eo = 1'b1;
    end else if (frac < (1 << 23)) begin
      ey = 32'h0;
      ez = 1'b1;
    end else begin
      ey = {s, 8'(ex), 23'(frac)};
    end
    ef = {ez, s & ~ez, m[24], eo};
`ifdef FP_NORM_FAST_EN
    lat = 3;
`else
    lat = 3 + k;
`endif
  endfunction

  task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] m,
                        input logic r, input int hold);
    logic [31:0] ey;
    logic [3:0]  ef;
    int          lat, cyc;
    bit          seen;
    model(s, e, m, r, ey, ef, lat);
    @(negedge clk);
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; in_round = r;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 1; seen = 0;
    while (!seen && cyc < 60) begin
      @(posedge clk);
      cyc++;
      #1;
      if (out_valid) seen = 1;
      else chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
    end
    if (!seen) begin
      chk("timeout", 32'd0, 32'd1);
      return;
    end
    chk("latency", cyc, lat);
    chk("y", y, ey);
    chk("flags", {28'b0, z, n, c, o}, {28'b0, ef});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      chk("hold_y", y, ey);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("post_valid", {31'b0, out_valid}, 32'd0);
    chk("post_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  function automatic logic [7:0] pick_exp();
    case ($urandom_range(0, 5))
      0: return 8'($urandom_range(0, 2));
      1: return 8'($urandom_range(252, 255));
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int seen_v;
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0;
    in_mant = '0; in_round = 1'b0; out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_flags", {28'b0, z, n, c, o}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

    // Directed cases
    run_op(1'b0, 8'h7F, 25'h1000000, 1'b0, 0);  // carry
    run_op(1'b0, 8'h80, 25'h0C00000, 1'b0, 5);  // normalised, back-pressure
    run_op(1'b0, 8'h7F, 25'h0000001, 1'b0, 0);  // full cancellation
    run_op(1'b0, 8'h7F, 25'h0FFFFFF, 1'b1, 0);  // round carry
    run_op(1'b0, 8'hFE, 25'h1000000, 1'b0, 0);  // overflow
    run_op(1'b1, 8'h40, 25'h0000000, 1'b0, 0);  // zero, negative sign
    run_op(1'b1, 8'h05, 25'h0000100, 1'b0, 0);  // exponent floor -> denormal
    run_op(1'b0, 8'h01, 25'h07FFFFF, 1'b1, 0);  // denormal rounds up to normal
    run_op(1'b1, 8'hFF, 25'h0800000, 1'b0, 0);  // exp already saturated
    run_op(1'b0, 8'h10, 25'h1000001, 1'b0, 0);  // carry with sticky bit

    // Reset during NORM: nothing must come out
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h7F; in_mant = 25'h0000001; in_round = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_rel_ready", {31'b0, in_ready}, 32'd1);
    seen_v = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1 if (out_valid) seen_v++;
    end
    chk("midrst_no_valid", seen_v, 32'd0);

    // Randomized
    for (int t = 0; t < 150; t++) begin
      logic [24:0] m;
      m = 25'($urandom);
      case ($urandom_range(0, 3))
        0: m = m >> $urandom_range(0, 24);
        1: m = {1'b0, m[23:0]};
        2: m = {2'b01, m[22:0]};
        default: ;
      endcase
      run_op(1'($urandom), pick_exp(), m, 1'($urandom), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
